// File: rtl/tmds_dec_if.sv
// Symbol-in / decoded-video-out bundle between a TMDS deserializer lane and its channel decoder.
// Streaming: one symbol is accepted every clk_pixel cycle with no backpressure; outputs are registered and valid every cycle.
interface tmds_dec_if;
    logic [9:0] tmds_symbol;
    logic [7:0] data;
    logic       de;
    logic [1:0] ctrl;
    logic       locked;
    logic       bitslip;
    logic [3:0] bitslip_count;
    logic [1:0] fsm_state;

    modport master (
        output tmds_symbol,
        input  data, de, ctrl, locked, bitslip, bitslip_count, fsm_state
    );

    modport slave (
        input  tmds_symbol,
        output data, de, ctrl, locked, bitslip, bitslip_count, fsm_state
    );
endinterface

// File: rtl/tmds_channel_decoder.sv
// One TMDS channel: 10b->8b decode plus word alignment by hunting for runs of control tokens
// and asking the deserializer to bitslip until a run shows up inside the search window.
module tmds_channel_decoder #(
    parameter int LOCK_TOKENS    = 8,
    parameter int SEARCH_WINDOW  = 2048,
    parameter int BITSLIP_SETTLE = 4
) (
    input  logic      clk_pixel,
    input  logic      reset,
    tmds_dec_if.slave dec_bus
);
    localparam int RW  = $clog2(LOCK_TOKENS + 1);
    localparam int WW  = $clog2(SEARCH_WINDOW);
    localparam int STW = $clog2(BITSLIP_SETTLE + 1);
    localparam logic [RW-1:0]  RUN_MAX     = RW'(LOCK_TOKENS);
    localparam logic [RW-1:0]  RUN_LAST    = RW'(LOCK_TOKENS - 1);
    localparam logic [WW-1:0]  WIN_LAST    = WW'(SEARCH_WINDOW - 1);
    localparam logic [STW-1:0] SETTLE_LAST = STW'(BITSLIP_SETTLE - 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [RW-1:0]  run_q, run_d;
    logic [WW-1:0]  win_q, win_d;
    logic [STW-1:0] settle_q, settle_d;
    logic [3:0]     count_q, count_d;
    logic           locked_q, locked_d;
    logic [7:0]     data_q, data_d;
    logic           de_q, de_d;
    logic [1:0]     ctrl_q, ctrl_d;

    logic       is_tok;
    logic [1:0] tok_code;
    logic [7:0] d_inv;
    logic [7:0] dec_byte;
    logic       hunting;
    logic       run_cplt;

    always_comb begin
        is_tok   = 1'b1;
        tok_code = 2'b00;
        case (dec_bus.tmds_symbol)
            10'h354: tok_code = 2'b00;
            10'h0AB: tok_code = 2'b01;
            10'h154: tok_code = 2'b10;
            10'h2AB: tok_code = 2'b11;
            default: is_tok   = 1'b0;
        endcase
    end

    always_comb begin
        d_inv       = dec_bus.tmds_symbol[9] ? ~dec_bus.tmds_symbol[7:0] : dec_bus.tmds_symbol[7:0];
        dec_byte    = '0;
        dec_byte[0] = d_inv[0];
        for (int i = 1; i < 8; i++) begin
            dec_byte[i] = dec_bus.tmds_symbol[8] ? (d_inv[i] ^ d_inv[i-1]) : ~(d_inv[i] ^ d_inv[i-1]);
        end
    end

    always_comb begin
        state_d  = state_q;
        run_d    = '0;
        win_d    = '0;
        settle_d = '0;
        count_d  = count_q;
        data_d   = '0;
        de_d     = 1'b0;
        ctrl_d   = 2'b00;

        hunting  = (state_q == ST_SEARCH) || (state_q == ST_LOCKED);
        // Only the token that lifts the run to LOCK_TOKENS completes it; a saturated run does not re-fire.
        run_cplt = hunting && is_tok && (run_q == RUN_LAST);

        if (hunting) begin
            run_d = is_tok ? ((run_q == RUN_MAX) ? RUN_MAX : run_q + RW'(1)) : '0;
            win_d = run_cplt ? '0 : win_q + WW'(1);
        end

        case (state_q)
            ST_SEARCH: begin
                if (run_cplt)               state_d = ST_LOCKED;
                else if (win_q == WIN_LAST) state_d = ST_SLIP;
            end
            ST_SLIP: begin
                state_d = ST_SETTLE;
                count_d = (count_q == 4'd9) ? 4'd0 : count_q + 4'd1;
            end
            ST_SETTLE: begin
                settle_d = settle_q + STW'(1);
                if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_SEARCH;
                    settle_d = '0;
                end
            end
            ST_LOCKED: begin
                if (!run_cplt && (win_q == WIN_LAST)) state_d = ST_SLIP;
            end
            default: state_d = ST_SEARCH;
        endcase

        // Registered lock lags the state by a cycle on entry but drops together with the move to SLIP.
        locked_d = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);

        if (locked_d) begin
            if (is_tok) begin
                ctrl_d = tok_code;
            end else begin
                de_d   = 1'b1;
                data_d = dec_byte;
                ctrl_d = ctrl_q;
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q  <= ST_SEARCH;
            run_q    <= '0;
            win_q    <= '0;
            settle_q <= '0;
            count_q  <= '0;
            locked_q <= 1'b0;
            data_q   <= '0;
            de_q     <= 1'b0;
            ctrl_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            win_q    <= win_d;
            settle_q <= settle_d;
            count_q  <= count_d;
            locked_q <= locked_d;
            data_q   <= data_d;
            de_q     <= de_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign dec_bus.data          = data_q;
    assign dec_bus.de            = de_q;
    assign dec_bus.ctrl          = ctrl_q;
    assign dec_bus.locked        = locked_q;
    assign dec_bus.bitslip       = (state_q == ST_SLIP);
    assign dec_bus.bitslip_count = count_q;
    assign dec_bus.fsm_state     = state_q;
endmodule
